// File: rtl/jpeg_zz_pkg.sv
// Shared JPEG zigzag definitions: block geometry, index types and the
// zigzag-to-raster table used by both the encoder and decoder reorder stages.
package jpeg_zz_pkg;

    localparam int unsigned BLK_SIZE = 64;
    localparam int unsigned IDX_W    = 6;

    typedef logic [IDX_W-1:0] zz_idx_t;
    typedef logic [IDX_W-1:0] ras_idx_t;

    // Entry k is the raster position of the k-th coefficient in zigzag order.
    localparam ras_idx_t ZZ2RAS [BLK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic ras_idx_t zz2ras(input zz_idx_t zz);
        return ZZ2RAS[zz];
    endfunction

endpackage

// File: rtl/jpeg_zz_lut.sv
// Combinational zigzag-index to raster-index lookup; the only point where
// the zigzag table is indexed in the decoder.
module jpeg_zz_lut
    import jpeg_zz_pkg::*;
(
    input  logic [IDX_W-1:0] zz_idx,
    output logic [IDX_W-1:0] ras_idx_c
);

    assign ras_idx_c = zz2ras(zz_idx);

endmodule

// File: rtl/jpeg_izigzag_buf.sv
// Inverse zigzag ping-pong buffer: writes zigzag-ordered coefficients into
// raster slots of one bank while the other bank drains in raster order.
module jpeg_izigzag_buf
    import jpeg_zz_pkg::*;
#(
    parameter int unsigned DW    = 12,
    parameter int unsigned NBANK = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sof,
    output logic          out_last,
    output logic          sync_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SIZE - 1);

    logic [DW-1:0]    mem [NBANK][BLK_SIZE];
    logic [NBANK-1:0] full;
    logic [NBANK-1:0] full_nxt;
    logic             wb;
    logic             rb;
    zz_idx_t          wcnt;
    zz_idx_t          wcnt_eff;
    ras_idx_t         rcnt;
    ras_idx_t         wr_addr;
    logic             in_fire;
    logic             out_fire;
    logic             wr_done;
    logic             rd_done;

    // An accepted in_sof always restarts the block at zigzag index 0.
    assign wcnt_eff = in_sof ? '0 : wcnt;
    assign in_ready = !full[wb];
    assign in_fire  = in_valid & in_ready;
    assign wr_done  = in_fire & (wcnt_eff == LAST_IDX);

    assign out_valid = full[rb];
    assign out_fire  = out_valid & out_ready;
    assign rd_done   = out_fire & (rcnt == LAST_IDX);
    assign out_data  = mem[rb][rcnt];
    assign out_sof   = out_valid & (rcnt == '0);
    assign out_last  = out_valid & (rcnt == LAST_IDX);

    jpeg_zz_lut u_lut (
        .zz_idx    (wcnt_eff),
        .ras_idx_c (wr_addr)
    );

    // Fill and drain always target different banks, so both updates can apply.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wb] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= '0;
            wb       <= 1'b0;
            rb       <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
            sync_err <= 1'b0;
        end else begin
            full <= full_nxt;
            if (in_fire) begin
                wcnt <= wcnt_eff + IDX_W'(1);
                if (wr_done) begin
                    wb <= ~wb;
                end
                if (in_sof && (wcnt != '0)) begin
                    sync_err <= 1'b1;
                end
            end
            if (out_fire) begin
                rcnt <= rcnt + IDX_W'(1);
                if (rd_done) begin
                    rb <= ~rb;
                end
            end
        end
    end

    // Coefficient storage carries no reset; validity is tracked by full.
    always_ff @(posedge clk) begin
        if (in_fire && !rst) begin
            mem[wb][wr_addr] <= in_data;
        end
    end

endmodule

// File: tb/tb_jpeg_izigzag_buf.sv
// Scoreboard bench for jpeg_izigzag_buf: expected raster streams are queued
// as blocks are issued and a negedge monitor compares every output beat.
module tb_jpeg_izigzag_buf;

    localparam int DW      = 12;
    localparam int TIMEOUT = 3000;

    // Raster position -> zigzag index (inverse of the JPEG zigzag scan).
    localparam int RAS2ZZ [64] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

    typedef logic [DW-1:0] blk_t [64];
    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          last;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_sof    = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_last;
    logic          sync_err;

    int   checks      = 0;
    int   fails       = 0;
    int   or_mode     = 0;
    int   pop_cnt     = 0;
    int   stream_chk  = 0;
    int   stream_outs = 0;
    int   bubbles     = 0;
    int   ir_drops    = 0;
    exp_t q [$];
    exp_t e;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    blk_t blk;
    blk_t blk2;
    int   base;

    jpeg_izigzag_buf #(.DW(DW), .NBANK(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_last  (out_last),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // out_ready policy: 0 stall, 1 always ready, 2 random 50%.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(prev_data));
            end
            if (stream_chk != 0) begin
                if (in_valid && !in_ready) ir_drops++;
                if (stream_outs > 0 && stream_outs < 256 && !out_valid) bubbles++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out: got data %0d with empty scoreboard", out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", int'(out_data), int'(e.d));
                    chk("out_sof", int'(out_sof), int'(e.sof));
                    chk("out_last", int'(out_last), int'(e.last));
                end
                pop_cnt++;
                if (stream_chk != 0) stream_outs++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic void gen_blk(input int b, output blk_t o);
        for (int k = 0; k < 64; k++) begin
            o[k] = (b == 0) ? DW'(k) : DW'(b * 131 + k * 37);
        end
    endfunction

    task automatic push_exp(input blk_t b);
        exp_t x;
        for (int r = 0; r < 64; r++) begin
            x.d    = b[RAS2ZZ[r]];
            x.sof  = (r == 0);
            x.last = (r == 63);
            q.push_back(x);
        end
    endtask

    // Entered and left at posedge+#1; returns once the beat has transferred.
    task automatic drive_coef(input logic [DW-1:0] d, input logic sof, input int idle_pct);
        int g;
        while (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct) begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        g = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            if (g > TIMEOUT) begin
                checks++;
                fails++;
                $display("FAIL in_accept_timeout: got in_ready=0 required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_blk(input blk_t b, input int idle_pct);
        for (int k = 0; k < 64; k++) drive_coef(b[k], k == 0, idle_pct);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) break;
        end
        chk("drain_queue_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_sync_err", int'(sync_err), 0);
        chk("rst_out_sof", int'(out_sof), 0);
        chk("rst_out_last", int'(out_last), 0);
        rst = 1'b0;

        // Single block, data = zigzag index.
        or_mode = 1;
        gen_blk(0, blk);
        push_exp(blk);
        for (int k = 0; k < 63; k++) drive_coef(blk[k], k == 0, 0);
        chk("pre_latency_valid", int'(out_valid), 0);
        drive_coef(blk[63], 1'b0, 0);
        chk("latency_valid", int'(out_valid), 1);
        chk("latency_sof", int'(out_sof), 1);
        chk("latency_data", int'(out_data), 0);
        idle_in();
        wait_drain();

        // Back-to-back streaming of four blocks.
        stream_chk = 1;
        for (int b = 1; b <= 4; b++) begin
            gen_blk(b, blk);
            push_exp(blk);
            send_blk(blk, 0);
        end
        idle_in();
        wait_drain();
        stream_chk = 0;
        chk("stream_outputs", stream_outs, 256);
        chk("stream_bubbles", bubbles, 0);
        chk("stream_in_ready_drops", ir_drops, 0);

        // Backpressure: both banks fill, then drain frees one.
        or_mode = 0;
        @(posedge clk);
        #1;
        gen_blk(5, blk);
        gen_blk(6, blk2);
        push_exp(blk);
        push_exp(blk2);
        send_blk(blk, 0);
        send_blk(blk2, 0);
        chk("bp_in_ready_low", int'(in_ready), 0);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = DW'(12'h7ff);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_hold_off", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        idle_in();
        or_mode = 1;
        begin
            int c;
            for (c = 0; c < TIMEOUT; c++) begin
                @(negedge clk);
                if (out_valid && out_ready && out_last) break;
            end
            chk("bp_last_seen", int'(c < TIMEOUT), 1);
        end
        chk("bp_ready_before_free", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("bp_ready_after_free", int'(in_ready), 1);
        wait_drain();

        // Random input gaps and random output stalls.
        or_mode = 2;
        for (int b = 7; b <= 26; b++) begin
            gen_blk(b, blk);
            push_exp(blk);
            send_blk(blk, 30);
        end
        idle_in();
        wait_drain();
        or_mode = 1;

        // Resync: in_sof arrives with 10 coefficients of a block pending.
        chk("pre_resync_sync_err", int'(sync_err), 0);
        gen_blk(27, blk);
        for (int k = 0; k < 10; k++) drive_coef(blk[k], k == 0, 0);
        chk("partial_no_output", int'(out_valid), 0);
        gen_blk(28, blk);
        push_exp(blk);
        drive_coef(blk[0], 1'b1, 0);
        chk("sync_err_set", int'(sync_err), 1);
        for (int k = 1; k < 64; k++) drive_coef(blk[k], 1'b0, 0);
        idle_in();
        wait_drain();
        chk("sync_err_sticky", int'(sync_err), 1);

        // Reset while draining at rcnt=30 with the other bank full.
        or_mode = 0;
        @(posedge clk);
        #1;
        gen_blk(29, blk);
        gen_blk(30, blk2);
        push_exp(blk);
        send_blk(blk, 0);
        send_blk(blk2, 0);
        idle_in();
        base    = pop_cnt;
        or_mode = 1;
        begin
            int c;
            for (c = 0; c < TIMEOUT; c++) begin
                @(posedge clk);
                #1;
                if (pop_cnt - base >= 30) break;
            end
            chk("mid_drain_reached", pop_cnt - base, 30);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_sync_err", int'(sync_err), 0);
        rst = 1'b0;
        q.delete();
        gen_blk(31, blk);
        push_exp(blk);
        send_blk(blk, 0);
        idle_in();
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/jpeg_izigzag_buf.md
Name: jpeg_izigzag_buf

Overview:
- Inverse zigzag reorder buffer for the JPEG decode/loopback path. It is the read-side counterpart of the encoder's zigzag stage.
- Accepts 64 quantised DCT coefficients per 8x8 block in zigzag order and emits the same coefficients in raster (row-major) order.
- Ping-pong double buffer, so one block fills while the previous block drains. Sustains 1 coefficient/cycle.
- Sits between the entropy/dequant stage and the IDCT.

Parameters:
- DW, 12, coefficient width in bits (signed, passed through unmodified).
- NBANK, 2, number of block banks. Fixed at 2; any other value is illegal.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  buffer can accept a coefficient this cycle.
- in_sof  in  1  first coefficient of a block (zigzag index 0); qualified by in_valid.
- in_data  in  DW  coefficient, zigzag order.
- out_valid  out  1  raster coefficient available.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  coefficient, raster order.
- out_sof  out  1  out_data is raster index 0.
- out_last  out  1  out_data is raster index 63.
- sync_err  out  1  sticky: in_sof seen with partial block in progress.

Behaviour:
- Handshakes: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready. valid never depends on ready. Data held stable while valid & !ready.
- State:
  - mem[2][64] x DW flops (not reset).
  - full[1:0].
  - wb, rb bank pointers (1b).
  - wcnt, rcnt (6b, wrap naturally 63->0).
- Reset (sync, any time, including mid-block): full=0, wb=rb=0, wcnt=rcnt=0, sync_err=0. Consequently out_valid=0, out_sof=0, out_last=0, in_ready=1. A partial block in flight is discarded.
- Write side:
  - in_ready = !full[wb].
  - On input transfer: mem[wb][ZZ2RAS[wcnt']] <= in_data, where wcnt' = (in_sof ? 0 : wcnt). Then wcnt <= wcnt'+1.
  - If wcnt'==63: full[wb] <= 1, wb toggles, wcnt <= 0.
- Sync rule: in_sof accepted while wcnt!=0 sets sync_err (sticky until rst). Write restarts at index 0 in the same bank; the partial block is overwritten. in_sof absent at wcnt==0 is legal (implicit block start).
- Read side:
  - out_valid = full[rb].
  - out_data = mem[rb][rcnt] (combinational from flops).
  - out_sof = out_valid & (rcnt==0); out_last = out_valid & (rcnt==63).
  - On output transfer: rcnt++. If rcnt==63: full[rb] <= 0, rb toggles.
- Latency: the cycle after the 64th input transfer, out_valid=1. Raster index 0 is presented immediately.
- Full: both banks full gives in_ready=0. A bank freed by the last read makes in_ready=1 on the next cycle; there is no same-cycle bypass.
- Empty: full[rb]=0 gives out_valid=0, and out_data is don't-care.
- Simultaneous events: a write completing bank A and a read completing bank B in the same cycle both take effect. The same bank cannot be both written and drained.
- ZZ2RAS is the standard JPEG zigzag table (zigzag idx -> raster idx), e.g. 0->0, 1->1, 2->8, 3->16, 4->9, 5->2, ..., 63->63.

Decomposition:
- Package jpeg_zz_pkg holds:
  - BLK_SIZE=64 and IDX_W=6.
  - typedef zz_idx_t / ras_idx_t (logic [5:0]).
  - The 64-entry ZZ2RAS constant array and the function zz2ras(). The same table is reused by the encoder zigzag.
- One sub-module, jpeg_zz_lut: combinational zz_idx -> ras_idx lookup wrapping the package function. It is the sole place the table is indexed, for equivalence checking against the encoder's table.

Test Plan:
- Single block: in_data = k at zigzag index k, in_sof on k=0, out_ready=1. Required response:
  - out_data sequence begins 0,1,5,6,14,15,27,28,2,4,7,13,... and ends ...,35,36,48,49,57,58,62,63.
  - out_sof on first beat, out_last on 64th.
  - out_valid first rises the cycle after the 64th input.
- Back-to-back streaming: 4 blocks of continuous input, out_ready=1. Required response: in_ready never drops, 256 outputs with no bubbles, each block correctly reordered.
- Backpressure: out_ready=0, then 128 inputs sent. Required response: in_ready=0 after the 128th input, 129th held off. Release out_ready; in_ready returns 1 the cycle after the 64th output.
- Random out_ready (50%) with random in_valid (70%), 20 blocks. Required response: scoreboard matches the raster reorder; out_data stable while stalled.
- Resync: in_sof at wcnt=10. Required response: sync_err=1 and stays 1; the following 64 coefficients form a correct block; no output is produced from the partial block.
- Reset mid-drain: rst at rcnt=30 with the other bank full. Required response:
  - Next cycle: out_valid=0, in_ready=1, sync_err=0.
  - A fresh block then reorders correctly.
